// File: rtl/cj_tty_host_monitor.sv
// cj_tty_host_monitor: tohost mailbox plus an 8N1 UART terminal with optional echo.
// Passive observer beside the SoC harness; nothing here can stall the SoC.
module cj_tty_host_monitor #(
  parameter int BAUD   = 115200,
  parameter int ECHO   = 0,
  parameter int CLK_HZ = 100_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        host_we,
  input  logic [63:0] host_wdata,
  output logic [63:0] tohost,
  output logic        done,
  output logic        pass,
  output logic [62:0] exit_code,
  input  logic        srx,
  output logic        stx,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_err,
  output logic        tx_busy
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tohost <= '0;
    end else if (host_we) begin
      tohost <= host_wdata;
    end
  end

  assign done      = tohost[0];
  assign exit_code = tohost[63:1];
  assign pass      = done && (tohost[63:1] == '0);

  // Synchronizer flops reset to the idle level so a release never looks like a start bit.
  logic s_meta, s, s_prev;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= srx;
      s      <= s_meta;
      s_prev <= s;
    end
  end

  logic fall;
  assign fall = s_prev & ~s;

  uart_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;

  // The counter is always zero in IDLE, so the free-running decrement needs no state guard.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (rx_cnt != '0) rx_cnt <= rx_cnt - CW'(1);
      case (rx_state)
        IDLE: begin
          if (fall) begin
            rx_cnt   <= HALF_LOAD;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == '0) begin
            if (!s) begin
              rx_cnt   <= FULL_LOAD;
              rx_idx   <= '0;
              rx_state <= DATA;
            end else begin
              rx_state <= IDLE;
            end
          end
        end
        DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {s, rx_shift[7:1]};
            rx_cnt   <= FULL_LOAD;
            rx_idx   <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) rx_state <= STOP;
          end
        end
        STOP: begin
          if (rx_cnt == '0) begin
            if (s) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            rx_state <= IDLE;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  generate
    if (ECHO != 0) begin : g_echo
      uart_state_t   tx_state;
      logic [CW-1:0] tx_cnt;
      logic [2:0]    tx_idx;
      logic [7:0]    tx_shift;

      // tx_idx counts the data bit currently on the line; pulses arriving while busy are dropped.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          tx_state <= IDLE;
          tx_cnt   <= '0;
          tx_idx   <= '0;
          tx_shift <= '0;
          stx      <= 1'b1;
          tx_busy  <= 1'b0;
        end else begin
          if (tx_cnt != '0) tx_cnt <= tx_cnt - CW'(1);
          case (tx_state)
            IDLE: begin
              if (rx_valid) begin
                tx_shift <= rx_data;
                tx_cnt   <= FULL_LOAD;
                stx      <= 1'b0;
                tx_busy  <= 1'b1;
                tx_state <= START;
              end
            end
            START: begin
              if (tx_cnt == '0) begin
                stx      <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_idx   <= '0;
                tx_cnt   <= FULL_LOAD;
                tx_state <= DATA;
              end
            end
            DATA: begin
              if (tx_cnt == '0) begin
                tx_cnt <= FULL_LOAD;
                if (tx_idx == 3'd7) begin
                  stx      <= 1'b1;
                  tx_state <= STOP;
                end else begin
                  stx      <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_idx   <= tx_idx + 3'd1;
                end
              end
            end
            STOP: begin
              if (tx_cnt == '0) begin
                tx_busy  <= 1'b0;
                tx_state <= IDLE;
              end
            end
            default: tx_state <= IDLE;
          endcase
        end
      end
    end else begin : g_no_echo
      assign stx     = 1'b1;
      assign tx_busy = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cj_tty_host_monitor.sv
// tb_cj_tty_host_monitor: randomized directed bench for the tohost mailbox and UART terminal.
// Expected pulse timing and echo waveforms come from a frame-level model of the 8N1 rules.
module tb_cj_tty_host_monitor;
  localparam int BAUD   = 115200;
  localparam int DIV    = 16;
  localparam int CLK_HZ = BAUD * DIV;
  localparam int FRAME  = 10 * DIV;
  localparam int RX_LAT = 2 + DIV / 2 + 9 * DIV + 1;
  localparam int MAXC   = 32768;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        host_we;
  logic [63:0] host_wdata;
  logic        srx;

  logic [63:0] tohost, tohost_ne;
  logic        done, pass, done_ne, pass_ne;
  logic [62:0] exit_code, exit_code_ne;
  logic        stx, rx_valid, rx_err, tx_busy;
  logic        stx_ne, rx_valid_ne, rx_err_ne, tx_busy_ne;
  logic [7:0]  rx_data, rx_data_ne;

  int vectors = 0;
  int miscompares = 0;

  cj_tty_host_monitor #(.BAUD(BAUD), .ECHO(1), .CLK_HZ(CLK_HZ)) dut (
    .clock(clock), .reset_n(reset_n), .host_we(host_we), .host_wdata(host_wdata),
    .tohost(tohost), .done(done), .pass(pass), .exit_code(exit_code),
    .srx(srx), .stx(stx), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_err(rx_err), .tx_busy(tx_busy)
  );

  cj_tty_host_monitor #(.BAUD(BAUD), .ECHO(0), .CLK_HZ(CLK_HZ)) dut_ne (
    .clock(clock), .reset_n(reset_n), .host_we(host_we), .host_wdata(host_wdata),
    .tohost(tohost_ne), .done(done_ne), .pass(pass_ne), .exit_code(exit_code_ne),
    .srx(srx), .stx(stx_ne), .rx_valid(rx_valid_ne), .rx_data(rx_data_ne),
    .rx_err(rx_err_ne), .tx_busy(tx_busy_ne)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Per-cycle record of the echo line plus every receive pulse, sampled mid-cycle.
  logic       stx_log  [MAXC];
  logic       busy_log [MAXC];
  int         valid_cyc[$];
  logic [7:0] valid_dat[$];
  int         err_cyc[$];
  int         ne_valid = 0;
  int         ne_bad = 0;

  always @(negedge clock) begin
    if (cyc < MAXC) begin
      stx_log[cyc]  = stx;
      busy_log[cyc] = tx_busy;
    end
    if (rx_valid === 1'b1) begin
      valid_cyc.push_back(cyc);
      valid_dat.push_back(rx_data);
    end
    if (rx_err === 1'b1) err_cyc.push_back(cyc);
    if (rx_valid_ne === 1'b1) ne_valid++;
    if (stx_ne !== 1'b1 || tx_busy_ne !== 1'b0) ne_bad++;
  end

  initial begin
    #(10 * (MAXC - 200));
    $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [63:0] mb;
  int exp_good = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic we, input logic [63:0] wdata);
    reset_n    = rst_n;
    host_we    = we;
    host_wdata = wdata;
    tick();
    host_we = 1'b0;
  endtask

  task automatic checkMailbox(input string tag);
    checkOutput({tag, " tohost"}, tohost, mb);
    checkOutput({tag, " done"}, done, mb[0]);
    checkOutput({tag, " pass"}, pass, mb == 64'd1);
    checkOutput({tag, " exit_code"}, exit_code, mb >> 1);
  endtask

  // Frame bit k (0 = start, 9 = stop) is driven for DIV cycles; ncyc < FRAME cuts the frame short.
  task automatic driveFrame(input logic [7:0] b, input logic stop, input int ncyc, output int d);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    d = cyc;
    for (int c = 0; c < ncyc; c++) begin
      srx = f[c / DIV];
      tick();
    end
    srx = 1'b1;
    if (stop && ncyc == FRAME) exp_good++;
  endtask

  task automatic checkRxGood(input string tag, input logic [7:0] b, input int d, input int nv0, input int ne0);
    checkOutput({tag, " valid count"}, valid_cyc.size() - nv0, 1);
    checkOutput({tag, " err count"}, err_cyc.size() - ne0, 0);
    if (valid_cyc.size() > nv0) begin
      checkOutput({tag, " valid cycle"}, valid_cyc[nv0], d + RX_LAT);
      checkOutput({tag, " data"}, valid_dat[nv0], b);
    end
  endtask

  task automatic checkEcho(input string tag, input logic [7:0] b, input int d);
    int v;
    int busy_n;
    logic [9:0] obs;
    logic [9:0] expct;
    v      = d + RX_LAT;
    expct  = {1'b1, b, 1'b0};
    busy_n = 0;
    for (int k = 0; k < 10; k++) obs[k] = stx_log[v + 1 + k * DIV + DIV / 2];
    for (int c = v + 1; c <= v + FRAME; c++) if (busy_log[c] === 1'b1) busy_n++;
    checkOutput({tag, " echo bits"}, obs, expct);
    checkOutput({tag, " echo start edge"}, {stx_log[v], stx_log[v + 1]}, 2'b10);
    checkOutput({tag, " busy length"}, busy_n, FRAME);
    checkOutput({tag, " busy bounds"}, {busy_log[v], busy_log[v + FRAME + 1]}, 2'b00);
  endtask

  task automatic checkIdle(input string tag, input int from, input int to);
    int bad;
    bad = 0;
    for (int c = from; c <= to; c++) if (stx_log[c] !== 1'b1 || busy_log[c] !== 1'b0) bad++;
    checkOutput({tag, " non-idle cycles"}, bad, 0);
  endtask

  initial begin
    logic [7:0]  rb, rb2, last_good;
    logic [63:0] wd;
    logic        we;
    int          d, d2, nv0, ne0;

    reset_n = 1'b0; host_we = 1'b1; host_wdata = 64'h1; srx = 1'b1;
    tick(3);
    mb = '0;
    checkMailbox("reset");
    checkOutput("reset stx", stx, 1'b1);
    checkOutput("reset tx_busy", tx_busy, 1'b0);
    checkOutput("reset rx_valid", rx_valid, 1'b0);
    checkOutput("reset rx_err", rx_err, 1'b0);
    checkOutput("reset rx_data", rx_data, 8'h00);

    host_we = 1'b0; reset_n = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, 64'h1); mb = 64'h1; checkMailbox("write 1");
    applyStimulus(1'b1, 1'b1, 64'h7); mb = 64'h7; checkMailbox("write 7");
    applyStimulus(1'b1, 1'b1, 64'h0); mb = 64'h0; checkMailbox("write 0");

    for (int i = 0; i < 8; i++) begin
      we = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) wd[63:1] = '0;
      applyStimulus(1'b1, we, wd);
      if (we) mb = wd;
      checkMailbox("random mailbox");
    end

    tick(5);
    nv0 = valid_cyc.size(); ne0 = err_cyc.size();
    driveFrame(8'hA5, 1'b1, FRAME, d);
    checkRxGood("rx A5", 8'hA5, d, nv0, ne0);
    last_good = 8'hA5;
    waitUntil(d + RX_LAT + FRAME + 4);
    checkEcho("A5", 8'hA5, d);
    checkOutput("rx_data holds A5", rx_data, last_good);

    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      tick($urandom_range(1, 30));
      nv0 = valid_cyc.size(); ne0 = err_cyc.size();
      driveFrame(rb, 1'b1, FRAME, d);
      checkRxGood("rx random", rb, d, nv0, ne0);
      last_good = rb;
      waitUntil(d + RX_LAT + FRAME + 4);
      checkEcho("random", rb, d);
    end

    // One idle cycle between frames is the tightest spacing at which both are echoed.
    rb = 8'h3C; rb2 = 8'($urandom);
    nv0 = valid_cyc.size(); ne0 = err_cyc.size();
    driveFrame(rb, 1'b1, FRAME, d);
    checkRxGood("gap1 first", rb, d, nv0, ne0);
    tick();
    nv0 = valid_cyc.size();
    driveFrame(rb2, 1'b1, FRAME, d2);
    checkRxGood("gap1 second", rb2, d2, nv0, ne0);
    last_good = rb2;
    waitUntil(d2 + RX_LAT + FRAME + 4);
    checkEcho("gap1 first", rb, d);
    checkEcho("gap1 second", rb2, d2);

    rb = 8'($urandom); rb2 = 8'($urandom);
    tick(3);
    nv0 = valid_cyc.size(); ne0 = err_cyc.size();
    driveFrame(rb, 1'b1, FRAME, d);
    checkRxGood("b2b first", rb, d, nv0, ne0);
    nv0 = valid_cyc.size();
    driveFrame(rb2, 1'b1, FRAME, d2);
    checkRxGood("b2b second", rb2, d2, nv0, ne0);
    last_good = rb2;
    waitUntil(d2 + RX_LAT + FRAME + 24);
    checkEcho("b2b first", rb, d);
    checkIdle("b2b dropped", d + RX_LAT + FRAME + 1, d2 + RX_LAT + FRAME + 20);

    rb = 8'($urandom);
    tick(5);
    nv0 = valid_cyc.size(); ne0 = err_cyc.size();
    driveFrame(rb, 1'b0, FRAME, d);
    tick(2);
    checkOutput("frame err count", err_cyc.size() - ne0, 1);
    checkOutput("frame err valid count", valid_cyc.size() - nv0, 0);
    if (err_cyc.size() > ne0) checkOutput("frame err cycle", err_cyc[ne0], d + RX_LAT);
    checkOutput("frame err rx_data kept", rx_data, last_good);
    waitUntil(d + RX_LAT + FRAME + 4);
    checkIdle("frame err no echo", d, d + RX_LAT + FRAME + 2);

    nv0 = valid_cyc.size(); ne0 = err_cyc.size();
    d = cyc;
    srx = 1'b0;
    tick(4);
    srx = 1'b1;
    tick(3 * DIV);
    checkOutput("glitch valid count", valid_cyc.size() - nv0, 0);
    checkOutput("glitch err count", err_cyc.size() - ne0, 0);
    checkIdle("glitch", d, cyc - 1);

    // Reset lands while RX is in data bit 4 of the second frame and TX in data bit 4 of the echo.
    rb = 8'($urandom); rb2 = 8'($urandom);
    nv0 = valid_cyc.size(); ne0 = err_cyc.size();
    driveFrame(rb, 1'b1, FRAME, d);
    checkRxGood("pre-reset frame", rb, d, nv0, ne0);
    nv0 = valid_cyc.size();
    driveFrame(rb2, 1'b1, 5 * DIV + 4, d2);
    reset_n = 1'b0;
    tick(2);
    mb = '0;
    checkMailbox("mid-frame reset");
    checkOutput("mid-frame reset stx", stx, 1'b1);
    checkOutput("mid-frame reset tx_busy", tx_busy, 1'b0);
    checkOutput("mid-frame reset rx_data", rx_data, 8'h00);
    reset_n = 1'b1;
    waitUntil(d2 + RX_LAT + FRAME + 4);
    checkOutput("aborted frame valid count", valid_cyc.size() - nv0, 0);
    checkOutput("aborted frame err count", err_cyc.size() - ne0, 0);
    checkIdle("after mid-frame reset", d2 + 5 * DIV + 5, cyc - 1);

    rb = 8'($urandom);
    nv0 = valid_cyc.size(); ne0 = err_cyc.size();
    driveFrame(rb, 1'b1, FRAME, d);
    checkRxGood("post-reset frame", rb, d, nv0, ne0);
    last_good = rb;
    waitUntil(d + RX_LAT + FRAME + 4);
    checkEcho("post-reset", rb, d);

    checkOutput("no-echo line idle", ne_bad, 0);
    checkOutput("no-echo valid count", ne_valid, exp_good);
    checkOutput("no-echo rx_data", rx_data_ne, last_good);
    checkOutput("total valid count", valid_cyc.size(), exp_good);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
